// File: rtl/trail_backtrack_if.sv
// Bus between the backtrack controller, the trail stack and the solver core.
// The slave modport is the backtrack unit's view.
interface trail_backtrack_if #(
    parameter int unsigned VAR_W   = 8,
    parameter int unsigned DEPTH_W = 6,
    parameter int unsigned LVL_W   = 4
);
    logic               trail_push;
    logic               decide;
    logic               bt_start;
    logic [LVL_W-1:0]   bt_level;
    logic [VAR_W:0]     stack_dout;
    logic               stack_empty;
    logic               stack_pop;
    logic               unassign_valid;
    logic [VAR_W-1:0]   unassign_var;
    logic               bt_busy;
    logic               bt_done;
    logic [LVL_W-1:0]   cur_level;
    logic [DEPTH_W-1:0] trail_depth;
    logic               error;

    modport slave (
        input  trail_push, decide, bt_start, bt_level, stack_dout, stack_empty,
        output stack_pop, unassign_valid, unassign_var, bt_busy, bt_done,
               cur_level, trail_depth, error
    );

    modport master (
        output trail_push, decide, bt_start, bt_level, stack_dout, stack_empty,
        input  stack_pop, unassign_valid, unassign_var, bt_busy, bt_done,
               cur_level, trail_depth, error
    );
endinterface

// File: rtl/trail_backtrack_unit.sv
// Backtrack controller: tracks trail depth and per-level trail boundaries,
// and on request pops the trail back to a target level, unassigning each variable.
module trail_backtrack_unit #(
    parameter int unsigned VAR_W     = 8,
    parameter int unsigned DEPTH_W   = 6,
    parameter int unsigned MAX_LEVEL = 15,
    parameter int unsigned LVL_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    trail_backtrack_if.slave bus
);

    localparam logic [LVL_W-1:0]   LVL_MAX   = LVL_W'(MAX_LEVEL);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    typedef enum logic [1:0] {IDLE, POP, CAP, DONE} state_t;

    state_t             state, state_nx;
    logic [LVL_W-1:0]   cur_level_q, tgt_level_q;
    logic [DEPTH_W-1:0] depth_q, target_q;
    logic [DEPTH_W-1:0] level_start [MAX_LEVEL];
    logic               error_q;

    logic               idle, push_ok, dec_ok, bt_go, bt_real, err_set;
    logic [LVL_W-1:0]   level_eff;
    logic [DEPTH_W-1:0] depth_dec, target_c;
    logic               unused_neg;

    // Push bookkeeping is applied before a same-cycle backtrack request is evaluated.
    always_comb begin
        idle      = (state == IDLE);
        push_ok   = idle && bus.trail_push && (depth_q != DEPTH_MAX);
        dec_ok    = push_ok && bus.decide && (cur_level_q != LVL_MAX);
        level_eff = dec_ok ? cur_level_q + LVL_W'(1) : cur_level_q;
        depth_dec = depth_q - DEPTH_W'(1);
        bt_go     = idle && bus.bt_start;
        bt_real   = bt_go && (bus.bt_level < level_eff);
        // The boundary of a level opened this very cycle is not in the table yet.
        target_c  = (dec_ok && (bus.bt_level == cur_level_q)) ? depth_q
                                                              : level_start[bus.bt_level];
        err_set   = (!idle && (bus.trail_push || bus.decide || bus.bt_start))
                 || (idle && bus.trail_push && (depth_q == DEPTH_MAX))
                 || (push_ok && bus.decide && (cur_level_q == LVL_MAX))
                 || ((state == POP) && bus.stack_empty);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bt_go) state_nx = bt_real ? POP : DONE;
            POP:  state_nx = bus.stack_empty ? IDLE : CAP;
            CAP:  state_nx = (depth_dec == target_q) ? DONE : POP;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_level_q <= '0;
            tgt_level_q <= '0;
            depth_q     <= '0;
            target_q    <= '0;
            error_q     <= 1'b0;
            for (int unsigned k = 0; k < MAX_LEVEL; k++) level_start[k] <= '0;
        end else begin
            error_q <= error_q | err_set;
            if (push_ok) depth_q <= depth_q + DEPTH_W'(1);
            if (dec_ok) begin
                level_start[cur_level_q] <= depth_q;
                cur_level_q              <= cur_level_q + LVL_W'(1);
            end
            if (bt_go) begin
                tgt_level_q <= bt_real ? bus.bt_level : level_eff;
                target_q    <= target_c;
            end
            if (state == CAP)  depth_q     <= depth_dec;
            if (state == DONE) cur_level_q <= tgt_level_q;
        end
    end

    // Strobes are decoded straight from the state register.
    assign bus.stack_pop      = (state == POP) && !bus.stack_empty;
    assign bus.unassign_valid = (state == CAP);
    assign bus.unassign_var   = (state == CAP) ? bus.stack_dout[VAR_W:1] : '0;
    assign bus.bt_busy        = (state == POP) || (state == CAP);
    assign bus.bt_done        = (state == DONE);
    assign bus.cur_level      = cur_level_q;
    assign bus.trail_depth    = depth_q;
    assign bus.error          = error_q;
    assign unused_neg         = bus.stack_dout[0];

endmodule

// File: tb/tb_trail_backtrack_unit.sv
// Directed bench for trail_backtrack_unit with a behavioural trail stack.
// Expected values are hand-derived from the literal sequences pushed.
module tb_trail_backtrack_unit;

    logic clock;
    logic reset;

    trail_backtrack_if #(.VAR_W(8), .DEPTH_W(6), .LVL_W(4)) bus ();

    trail_backtrack_unit #(.VAR_W(8), .DEPTH_W(6), .MAX_LEVEL(15), .LVL_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Trail stack model
    logic [8:0] stk [$];
    int         stk_n = 0;
    logic [8:0] push_lit;
    logic       accept;
    logic       force_empty;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            stk.delete();
            bus.stack_dout <= '0;
        end else begin
            if (bus.stack_pop && stk.size() > 0) bus.stack_dout <= stk.pop_back();
            if (bus.trail_push && accept) stk.push_back(push_lit);
        end
        stk_n = stk.size();
    end
    assign bus.stack_empty = (stk_n == 0) || force_empty;

    // Monitor
    int         cyc = 0;
    int         pop_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [7:0] ulog [$];

    always @(posedge clock) cyc++;
    always @(negedge clock) begin
        if (reset) begin
            if (bus.unassign_valid) ulog.push_back(bus.unassign_var);
            if (bus.stack_pop) pop_cnt++;
            if (bus.bt_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // All driver tasks start and end at #1 after a rising edge.
    task automatic push(input int v, input bit dec);
        bus.trail_push = 1'b1;
        bus.decide     = dec;
        push_lit       = 9'(v << 1);
        accept         = 1'b1;
        @(posedge clock); #1;
        bus.trail_push = 1'b0;
        bus.decide     = 1'b0;
        accept         = 1'b0;
    endtask

    task automatic start_bt(input int lvl, output int t0);
        bus.bt_start = 1'b1;
        bus.bt_level = 4'(lvl);
        @(posedge clock); #1;
        t0 = cyc;
        bus.bt_start = 1'b0;
    endtask

    task automatic wait_done(input int snap);
        for (int i = 0; i < 100; i++) begin
            if (done_cnt > snap) break;
            @(posedge clock); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.cur_level !== 4'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", bus.cur_level); end
        n_cmp++; if (bus.trail_depth !== 6'd0) begin n_bad++; $display("FAIL reset_depth got %0d want 0", bus.trail_depth); end
        n_cmp++; if ({bus.error, bus.bt_busy, bus.bt_done, bus.stack_pop, bus.unassign_valid} !== 5'b0)
            begin n_bad++; $display("FAIL reset_flags got %b want 00000", {bus.error, bus.bt_busy, bus.bt_done, bus.stack_pop, bus.unassign_valid}); end
        n_cmp++; if (bus.unassign_var !== 8'd0) begin n_bad++; $display("FAIL reset_var got %0d want 0", bus.unassign_var); end
    endtask

    task automatic test_single();
        int t0, ls, ps, ds;
        push(3, 1); push(5, 0); push(7, 0);
        n_cmp++; if (bus.trail_depth !== 6'd3) begin n_bad++; $display("FAIL single_depth_pre got %0d want 3", bus.trail_depth); end
        n_cmp++; if (bus.cur_level !== 4'd1) begin n_bad++; $display("FAIL single_level_pre got %0d want 1", bus.cur_level); end
        ls = ulog.size(); ps = pop_cnt; ds = done_cnt;
        start_bt(0, t0);
        n_cmp++; if (bus.bt_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", bus.bt_busy); end
        wait_done(ds);
        n_cmp++; if (done_cnt !== ds + 1) begin n_bad++; $display("FAIL single_done got %0d want %0d", done_cnt - ds, 1); end
        // bt_done lands in the 7th cycle counted from the request edge
        n_cmp++; if (done_cyc - t0 !== 6) begin n_bad++; $display("FAIL single_latency got %0d want 6", done_cyc - t0); end
        n_cmp++; if (pop_cnt - ps !== 3) begin n_bad++; $display("FAIL single_pops got %0d want 3", pop_cnt - ps); end
        n_cmp++; if (ulog.size() - ls !== 3) begin n_bad++; $display("FAIL single_ucount got %0d want 3", ulog.size() - ls); end
        else begin
            n_cmp++; if ({ulog[ls], ulog[ls+1], ulog[ls+2]} !== {8'd7, 8'd5, 8'd3})
                begin n_bad++; $display("FAIL single_vars got %0d,%0d,%0d want 7,5,3", ulog[ls], ulog[ls+1], ulog[ls+2]); end
        end
        n_cmp++; if (bus.trail_depth !== 6'd0) begin n_bad++; $display("FAIL single_depth got %0d want 0", bus.trail_depth); end
        n_cmp++; if (bus.cur_level !== 4'd0) begin n_bad++; $display("FAIL single_level got %0d want 0", bus.cur_level); end
    endtask

    task automatic test_multi();
        int t0, ls, ds;
        push(1, 1); push(2, 0); push(4, 1); push(9, 0); push(6, 1);
        n_cmp++; if (bus.cur_level !== 4'd3) begin n_bad++; $display("FAIL multi_level_pre got %0d want 3", bus.cur_level); end
        n_cmp++; if (bus.trail_depth !== 6'd5) begin n_bad++; $display("FAIL multi_depth_pre got %0d want 5", bus.trail_depth); end
        ls = ulog.size(); ds = done_cnt;
        start_bt(1, t0);
        wait_done(ds);
        n_cmp++; if (done_cyc - t0 !== 6) begin n_bad++; $display("FAIL multi_latency got %0d want 6", done_cyc - t0); end
        n_cmp++; if (ulog.size() - ls !== 3) begin n_bad++; $display("FAIL multi_ucount got %0d want 3", ulog.size() - ls); end
        else begin
            n_cmp++; if ({ulog[ls], ulog[ls+1], ulog[ls+2]} !== {8'd6, 8'd9, 8'd4})
                begin n_bad++; $display("FAIL multi_vars got %0d,%0d,%0d want 6,9,4", ulog[ls], ulog[ls+1], ulog[ls+2]); end
        end
        n_cmp++; if (bus.trail_depth !== 6'd2) begin n_bad++; $display("FAIL multi_depth got %0d want 2", bus.trail_depth); end
        n_cmp++; if (bus.cur_level !== 4'd1) begin n_bad++; $display("FAIL multi_level got %0d want 1", bus.cur_level); end
        n_cmp++; if (stk_n !== 2) begin n_bad++; $display("FAIL multi_retained got %0d want 2", stk_n); end
    endtask

    task automatic test_noop();
        int t0, ls, ps, ds;
        push(3, 1);
        ls = ulog.size(); ps = pop_cnt; ds = done_cnt;
        start_bt(2, t0);
        wait_done(ds);
        n_cmp++; if (done_cnt !== ds + 1) begin n_bad++; $display("FAIL noop_done got %0d want 1", done_cnt - ds); end
        n_cmp++; if (done_cyc - t0 !== 0) begin n_bad++; $display("FAIL noop_latency got %0d want 0", done_cyc - t0); end
        n_cmp++; if ((pop_cnt - ps) + (ulog.size() - ls) !== 0) begin n_bad++; $display("FAIL noop_pulses got %0d want 0", (pop_cnt - ps) + (ulog.size() - ls)); end
        n_cmp++; if ({bus.cur_level, bus.trail_depth} !== {4'd2, 6'd3}) begin n_bad++; $display("FAIL noop_state got lvl %0d depth %0d want lvl 2 depth 3", bus.cur_level, bus.trail_depth); end
        n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL noop_error got %b want 0", bus.error); end
    endtask

    // Decision push and backtrack request in the same cycle
    task automatic test_push_and_bt();
        int t0, ls, ds;
        ls = ulog.size(); ds = done_cnt;
        bus.trail_push = 1'b1; bus.decide = 1'b1; push_lit = 9'(7 << 1); accept = 1'b1;
        bus.bt_start = 1'b1; bus.bt_level = 4'd2;
        @(posedge clock); #1;
        t0 = cyc;
        bus.trail_push = 1'b0; bus.decide = 1'b0; accept = 1'b0; bus.bt_start = 1'b0;
        wait_done(ds);
        n_cmp++; if (done_cyc - t0 !== 2) begin n_bad++; $display("FAIL same_latency got %0d want 2", done_cyc - t0); end
        n_cmp++; if (ulog.size() - ls !== 1) begin n_bad++; $display("FAIL same_ucount got %0d want 1", ulog.size() - ls); end
        else begin
            n_cmp++; if (ulog[ls] !== 8'd7) begin n_bad++; $display("FAIL same_var got %0d want 7", ulog[ls]); end
        end
        n_cmp++; if ({bus.cur_level, bus.trail_depth} !== {4'd2, 6'd3}) begin n_bad++; $display("FAIL same_state got lvl %0d depth %0d want lvl 2 depth 3", bus.cur_level, bus.trail_depth); end
    endtask

    task automatic test_busy_push();
        int t0, ls, ds;
        ls = ulog.size(); ds = done_cnt;
        start_bt(0, t0);
        bus.trail_push = 1'b1;
        @(posedge clock); #1;
        bus.trail_push = 1'b0;
        wait_done(ds);
        n_cmp++; if (bus.error !== 1'b1) begin n_bad++; $display("FAIL busy_error got %b want 1", bus.error); end
        n_cmp++; if (bus.trail_depth !== 6'd0) begin n_bad++; $display("FAIL busy_depth got %0d want 0", bus.trail_depth); end
        n_cmp++; if (ulog.size() - ls !== 3) begin n_bad++; $display("FAIL busy_ucount got %0d want 3", ulog.size() - ls); end
        else begin
            n_cmp++; if ({ulog[ls], ulog[ls+1], ulog[ls+2]} !== {8'd3, 8'd2, 8'd1})
                begin n_bad++; $display("FAIL busy_vars got %0d,%0d,%0d want 3,2,1", ulog[ls], ulog[ls+1], ulog[ls+2]); end
        end
    endtask

    task automatic test_empty_pop();
        int t0, ps, ds;
        do_reset();
        push(5, 1); push(6, 1);
        ps = pop_cnt; ds = done_cnt;
        force_empty = 1'b1;
        start_bt(1, t0);
        repeat (3) @(posedge clock);
        #1 force_empty = 1'b0;
        n_cmp++; if (bus.error !== 1'b1) begin n_bad++; $display("FAIL empty_error got %b want 1", bus.error); end
        n_cmp++; if (bus.bt_busy !== 1'b0) begin n_bad++; $display("FAIL empty_busy got %b want 0", bus.bt_busy); end
        n_cmp++; if ({bus.cur_level, bus.trail_depth} !== {4'd2, 6'd2}) begin n_bad++; $display("FAIL empty_state got lvl %0d depth %0d want lvl 2 depth 2", bus.cur_level, bus.trail_depth); end
        n_cmp++; if ((pop_cnt - ps) + (done_cnt - ds) !== 0) begin n_bad++; $display("FAIL empty_pulses got %0d want 0", (pop_cnt - ps) + (done_cnt - ds)); end
    endtask

    task automatic test_reset_mid();
        int t0, ls, ps;
        bit hit;
        do_reset();
        push(1, 1); push(2, 0); push(3, 0);
        ls = ulog.size();
        hit = 1'b0;
        start_bt(0, t0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); #1;
            if (ulog.size() - ls >= 2) begin hit = 1'b1; break; end
        end
        n_cmp++; if (hit !== 1'b1) begin n_bad++; $display("FAIL mid_reach got %b want 1", hit); end
        reset = 1'b0;
        #1;
        n_cmp++; if ({bus.unassign_valid, bus.bt_busy, bus.stack_pop, bus.bt_done} !== 4'b0)
            begin n_bad++; $display("FAIL mid_flags got %b want 0000", {bus.unassign_valid, bus.bt_busy, bus.stack_pop, bus.bt_done}); end
        n_cmp++; if ({bus.cur_level, bus.trail_depth} !== 10'd0) begin n_bad++; $display("FAIL mid_state got lvl %0d depth %0d want 0 0", bus.cur_level, bus.trail_depth); end
        @(posedge clock); #1;
        reset = 1'b1;
        ps = pop_cnt;
        repeat (10) @(posedge clock);
        #1;
        n_cmp++; if (pop_cnt - ps !== 0) begin n_bad++; $display("FAIL mid_no_pop got %0d want 0", pop_cnt - ps); end
        n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL mid_error got %b want 0", bus.error); end
    endtask

    initial begin
        reset          = 1'b0;
        bus.trail_push = 1'b0;
        bus.decide     = 1'b0;
        bus.bt_start   = 1'b0;
        bus.bt_level   = '0;
        push_lit       = '0;
        accept         = 1'b0;
        force_empty    = 1'b0;
        #1;
        test_reset();
        test_single();
        test_multi();
        test_noop();
        test_push_and_bt();
        test_busy_push();
        test_empty_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
